// File: rtl/fadd_result_collector.sv
// Purpose: collect FLOAT_ADD results into an in-order FIFO and hand out issue credits.
// Latency: 1 cycle from res_valid to out_valid/out_data (registered FWFT head, no bypass).
// Backpressure: out_valid/out_ready downstream; upstream is throttled by issue_allow credits.
// Optional feature macro: FADD_CLASSIFY_EN adds out_class and nan_seen.
module fadd_result_collector #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              issue,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              issue_allow,
  output logic [CNT_W-1:0]  inflight,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              err_overrun,
  output logic              err_orphan,
  output logic              err_drop
`ifdef FADD_CLASSIFY_EN
  ,
  output logic [2:0]        out_class,
  output logic              nan_seen
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef FADD_CLASSIFY_EN
  localparam int FW = DATA_W + 3;
`else
  localparam int FW = DATA_W;
`endif

  logic [FW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_inflight;
  logic             r_out_valid;
  logic [FW-1:0]    r_head;
  logic             r_err_overrun;
  logic             r_err_orphan;
  logic             r_err_drop;

  logic             w_pop;
  logic             w_full;
  logic             w_push;
  logic [CNT_W-1:0] w_count_n;
  logic [CNT_W-1:0] w_left;
  logic [AW-1:0]    w_rptr_n;
  logic [CNT_W:0]   w_occ;
  logic [FW-1:0]    w_entry;
  logic [FW-1:0]    w_head_n;

`ifdef FADD_CLASSIFY_EN
  logic [2:0]       w_class;
  logic [10:0]      w_exp;
  logic [51:0]      w_man;
  logic             r_nan_seen;

  // Decode the IEEE-754 class of the incoming result at push time.
  always_comb begin
    w_exp   = res_data[62:52];
    w_man   = res_data[51:0];
    w_class = 3'd2;
    if (w_exp == 11'd0) begin
      w_class = (w_man == 52'd0) ? 3'd0 : 3'd1;
    end else if (&w_exp) begin
      w_class = (w_man == 52'd0) ? 3'd3 : 3'd4;
    end
  end

  assign w_entry = {w_class, res_data};
`else
  assign w_entry = res_data;
`endif

  // Full/empty come from the occupancy counter so pointer equality is never ambiguous.
  assign w_pop     = r_out_valid & out_ready;
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_push    = res_valid & (~w_full | w_pop);
  assign w_count_n = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_left    = r_count - CNT_W'(w_pop);
  assign w_rptr_n  = r_rptr + AW'(w_pop);

  // Credits cover both buffered and still-in-flight results; only registers feed this.
  assign w_occ       = {1'b0, r_count} + {1'b0, r_inflight};
  assign issue_allow = (w_occ < (CNT_W+1)'(DEPTH));

  // Next head: the incoming word when nothing else remains, otherwise the next stored entry.
  always_comb begin
    w_head_n = r_head;
    if (w_count_n != '0) begin
      if (w_left == '0) begin
        w_head_n = w_entry;
      end else begin
        w_head_n = r_mem[w_rptr_n];
      end
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr      <= w_rptr_n;
      r_count     <= w_count_n;
      r_out_valid <= (w_count_n != '0);
      r_head      <= w_head_n;
    end
  end

  // In-flight tracking: every returned result consumes a credit, even when dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= '0;
    end else if (issue && !res_valid) begin
      if (r_inflight != {CNT_W{1'b1}}) begin
        r_inflight <= r_inflight + CNT_W'(1);
      end
    end else if (!issue && res_valid) begin
      if (r_inflight != '0) begin
        r_inflight <= r_inflight - CNT_W'(1);
      end
    end
  end

  // Sticky protocol error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_overrun <= 1'b0;
      r_err_orphan  <= 1'b0;
      r_err_drop    <= 1'b0;
    end else begin
      if (issue && !issue_allow) begin
        r_err_overrun <= 1'b1;
      end
      if (res_valid && !issue && (r_inflight == '0)) begin
        r_err_orphan <= 1'b1;
      end
      if (res_valid && !w_push) begin
        r_err_drop <= 1'b1;
      end
    end
  end

`ifdef FADD_CLASSIFY_EN
  // Sticky NaN indicator, set when a NaN is actually stored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_nan_seen <= 1'b0;
    end else if (w_push && (w_class == 3'd4)) begin
      r_nan_seen <= 1'b1;
    end
  end

  assign out_class = r_head[FW-1 -: 3];
  assign nan_seen  = r_nan_seen;
`endif

  assign out_valid   = r_out_valid;
  assign out_data    = r_head[DATA_W-1:0];
  assign inflight    = r_inflight;
  assign err_overrun = r_err_overrun;
  assign err_orphan  = r_err_orphan;
  assign err_drop    = r_err_drop;

endmodule
